// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register file writeback path.
// Holds the write request record used by both writeback sources.
package regfile_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    return NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard for in-flight MDU operations.
// Drives the decode stall and flags a second issue to an already pending rd.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  clr,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  stall,
  output logic                  double_issue
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic                clr_hits_issue;

  always_comb begin
    set_mask       = '0;
    clr_mask       = '0;
    clr_hits_issue = clr && (clr_rd == issue_rd);
    if (issue && (issue_rd != '0)) begin
      set_mask = reg_onehot(issue_rd);
    end
    if (clr) begin
      clr_mask = reg_onehot(clr_rd);
    end
    // A retiring writeback to the same rd frees the slot for the new issue.
    double_issue = rst && (|(set_mask & pending_q)) && !clr_hits_issue;
    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Evaluated on the registered vector only: no same-cycle bypass.
  always_comb begin
    stall = rst && (pending_q[rs1] || pending_q[rs2] || pending_q[rd]);
  end

endmodule

// File: rtl/regfile_wb_arb.sv
// Register file write-port arbiter between the WB stage and the MDU, with
// bounded MDU starvation via a one-cycle pipeline hold and a sticky error flag.
module regfile_wb_arb
  import regfile_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we_i,
  input  logic [REG_ADDR_W-1:0] pipe_waddr_i,
  input  logic [XLEN-1:0]       pipe_wdata_i,
  input  logic                  mdu_valid_i,
  input  logic [REG_ADDR_W-1:0] mdu_waddr_i,
  input  logic [XLEN-1:0]       mdu_wdata_i,
  output logic                  mdu_ready_o,
  input  logic                  mdu_issue_i,
  input  logic [REG_ADDR_W-1:0] mdu_issue_rd_i,
  input  logic [REG_ADDR_W-1:0] dec_rs1_i,
  input  logic [REG_ADDR_W-1:0] dec_rs2_i,
  input  logic [REG_ADDR_W-1:0] dec_rd_i,
  output logic                  stall_o,
  output logic                  pipe_hold_o,
  output logic                  we_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic [XLEN-1:0]       wdata_o,
  output logic                  err_o
);

  localparam logic [CNT_W-1:0] cnt_limit = CNT_W'(STARVE_LIMIT);

  logic             grant_mdu;
  logic             grant_pipe;
  wb_req_t          pipe_req;
  wb_req_t          mdu_req;
  wb_req_t          sel_req;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             hold_q;
  logic             hold_d;
  logic             err_q;
  logic             err_d;
  logic             double_issue;

  // Grant is purely combinational; reset suppresses both grants.
  always_comb begin
    grant_mdu  = rst && mdu_valid_i && (!pipe_we_i || hold_q);
    grant_pipe = rst && pipe_we_i && !grant_mdu;
  end

  always_comb begin
    pipe_req.we    = grant_pipe;
    pipe_req.waddr = pipe_waddr_i;
    pipe_req.wdata = pipe_wdata_i;
    mdu_req.we     = grant_mdu;
    mdu_req.waddr  = mdu_waddr_i;
    mdu_req.wdata  = mdu_wdata_i;
  end

  always_comb begin
    sel_req = '0;
    if (mdu_req.we) begin
      sel_req = mdu_req;
    end else if (pipe_req.we) begin
      sel_req = pipe_req;
    end
  end

  // A granted write to x0 still completes the handshake but never reaches the file.
  always_comb begin
    we_o        = sel_req.we && (sel_req.waddr != '0);
    waddr_o     = sel_req.waddr;
    wdata_o     = sel_req.wdata;
    mdu_ready_o = grant_mdu;
    pipe_hold_o = hold_q;
    err_o       = err_q;
  end

  always_comb begin
    cnt_d = cnt_q;
    // The hold cycle always restarts the count so the hold stays one cycle wide.
    if (grant_mdu || hold_q) begin
      cnt_d = '0;
    end else if (mdu_valid_i && (cnt_q != cnt_limit)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    hold_d = (cnt_d == cnt_limit);
    err_d  = err_q || (pipe_we_i && hold_q) || double_issue;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      hold_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      err_q  <= err_d;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .issue        (mdu_issue_i),
    .issue_rd     (mdu_issue_rd_i),
    .clr          (grant_mdu),
    .clr_rd       (mdu_waddr_i),
    .rs1          (dec_rs1_i),
    .rs2          (dec_rs2_i),
    .rd           (dec_rd_i),
    .stall        (stall_o),
    .double_issue (double_issue)
  );

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed cycle table, hand sequences for
// errors and reset, then random traffic against a behavioural model.
module tb_regfile_wb_arb;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mdu_valid;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        mdu_ready;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_rd;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        stall, pipe_hold, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        err;

  int passed = 0;
  int total  = 0;

  regfile_wb_arb #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .pipe_we_i      (pipe_we),
    .pipe_waddr_i   (pipe_waddr),
    .pipe_wdata_i   (pipe_wdata),
    .mdu_valid_i    (mdu_valid),
    .mdu_waddr_i    (mdu_waddr),
    .mdu_wdata_i    (mdu_wdata),
    .mdu_ready_o    (mdu_ready),
    .mdu_issue_i    (mdu_issue),
    .mdu_issue_rd_i (mdu_issue_rd),
    .dec_rs1_i      (dec_rs1),
    .dec_rs2_i      (dec_rs2),
    .dec_rd_i       (dec_rd),
    .stall_o        (stall),
    .pipe_hold_o    (pipe_hold),
    .we_o           (we),
    .waddr_o        (waddr),
    .wdata_o        (wdata),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        iss;
    logic [4:0]  ird;
    logic [4:0]  rs1, rs2, rd;
    logic        e_ready, e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_stall, e_hold, e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_all(input string tag, input logic e_ready, input logic e_we,
                         input logic [4:0] e_waddr, input logic [31:0] e_wdata,
                         input logic e_stall, input logic e_hold, input logic e_err);
    chk({tag, " mdu_ready"}, 32'(mdu_ready), 32'(e_ready));
    chk({tag, " we"},        32'(we),        32'(e_we));
    chk({tag, " waddr"},     32'(waddr),     32'(e_waddr));
    chk({tag, " wdata"},     wdata,          e_wdata);
    chk({tag, " stall"},     32'(stall),     32'(e_stall));
    chk({tag, " pipe_hold"}, 32'(pipe_hold), 32'(e_hold));
    chk({tag, " err"},       32'(err),       32'(e_err));
  endtask

  task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic iss, input logic [4:0] ird,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
    mdu_issue = iss; mdu_issue_rd = ird;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Inputs change 1 after the edge, outputs are sampled 4 later.
  task automatic settle();
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic vec_t mk(logic pw, logic [4:0] pa, logic [31:0] pd,
                              logic mv, logic [4:0] ma, logic [31:0] md,
                              logic iss, logic [4:0] ird,
                              logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic e_ready, logic e_we, logic [4:0] e_waddr,
                              logic [31:0] e_wdata, logic e_stall, logic e_hold,
                              logic e_err);
    vec_t v;
    v.pw = pw; v.pa = pa; v.pd = pd; v.mv = mv; v.ma = ma; v.md = md;
    v.iss = iss; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.e_ready = e_ready; v.e_we = e_we; v.e_waddr = e_waddr; v.e_wdata = e_wdata;
    v.e_stall = e_stall; v.e_hold = e_hold; v.e_err = e_err;
    return v;
  endfunction

  // Behavioural reference state for the random phase.
  bit          m_pend[32];
  int          m_blocked;
  bit          m_hold, m_err;
  bit          waiting;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  initial begin
    rst = 1'b0;
    idle();
    tick();
    // Reset values while rst is still low.
    settle();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;

    // Arbitration
    tbl.push_back(mk(1, 5, 32'hAAAA_0001, 1, 6, 32'h6666_0006, 0, 0, 0, 0, 0,
                     0, 1, 5, 32'hAAAA_0001, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 6, 32'h6666_0006, 0, 0, 0, 0, 0,
                     1, 1, 6, 32'h6666_0006, 0, 0, 0));
    // Starvation: four blocked cycles, hold in the fifth with pipe dropped
    for (int i = 1; i <= 4; i++) begin
      tbl.push_back(mk(1, 1, 32'(i), 1, 9, 32'h99, 0, 0, 0, 0, 0,
                       0, 1, 1, 32'(i), 0, 0, 0));
    end
    tbl.push_back(mk(0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 1, 1, 9, 32'h99, 0, 1, 0));
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0, 0));
    // Scoreboard
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 10, 32'h10, 0, 0, 10, 0, 0, 1, 1, 10, 32'h10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 10, 32'h20, 1, 10, 10, 0, 0, 1, 1, 10, 32'h20, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 10, 32'h30, 0, 0, 0, 10, 0, 1, 1, 10, 32'h30, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0));
    // x0 handling
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 1, 0, 0, 32'hDEAD, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].pw, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md,
            tbl[i].iss, tbl[i].ird, tbl[i].rs1, tbl[i].rs2, tbl[i].rd);
      settle();
      chk_all($sformatf("row%0d", i), tbl[i].e_ready, tbl[i].e_we, tbl[i].e_waddr,
              tbl[i].e_wdata, tbl[i].e_stall, tbl[i].e_hold, tbl[i].e_err);
      tick();
    end

    // Hold violation: pipe keeps writing through the hold cycle
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 32'h22, 1, 3, 32'h33, 0, 0, 0, 0, 0);
      settle();
      chk("hv blocked hold", 32'(pipe_hold), 0);
      tick();
    end
    drive(1, 2, 32'h22, 1, 3, 32'h33, 0, 0, 0, 0, 0);
    settle();
    chk_all("hv hold", 1, 1, 3, 32'h33, 0, 1, 0);
    tick();
    drive(1, 2, 32'h22, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk_all("hv after", 0, 1, 2, 32'h22, 0, 0, 1);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("hv sticky err", 32'(err), 1);
      tick();
    end
    rst = 1'b0;
    drive(1, 2, 32'h22, 1, 3, 32'h33, 0, 0, 0, 0, 0);
    settle();
    chk("hv rst we", 32'(we), 0);
    chk("hv rst ready", 32'(mdu_ready), 0);
    tick();
    rst = 1'b1;
    idle();
    settle();
    chk("hv err cleared", 32'(err), 0);
    tick();

    // Double issue to pending x7
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    settle();
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0);
    settle();
    chk("di stall", 32'(stall), 1);
    chk("di err early", 32'(err), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0);
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("di err", 32'(err), 1);
      chk("di still pending", 32'(stall), 1);
      tick();
    end
    rst = 1'b0;
    settle();
    chk("di rst stall", 32'(stall), 0);
    tick();
    rst = 1'b1;
    settle();
    chk("di err cleared", 32'(err), 0);
    chk("di pending cleared", 32'(stall), 0);
    tick();

    // Reset mid-wait: cnt=3, pending[12]=1
    drive(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0);
    settle();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h11, 1, 4, 32'h44, 0, 0, 12, 0, 0);
      settle();
      chk("rw pre stall", 32'(stall), 1);
      tick();
    end
    rst = 1'b0;
    settle();
    chk_all("rw in reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk_all($sformatf("rw fresh%0d", i), 0, 1, 1, 32'h11, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 4, 32'h44, 0, 0, 12, 0, 0);
    settle();
    chk_all("rw hold", 1, 1, 4, 32'h44, 0, 1, 0);
    tick();
    idle();
    settle();
    chk("rw hold drop", 32'(pipe_hold), 0);
    tick();

    // Random traffic against the reference model
    do_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_blocked = 0; m_hold = 0; m_err = 0; waiting = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic        r, pw, iss, wins, e_stall;
      logic [4:0]  pa, ird, rs1, rs2, rd, e_addr;
      logic [31:0] pd, e_data;
      r = ($urandom_range(99) != 0);
      if (!waiting && ($urandom_range(2) == 0)) begin
        waiting = 1;
        w_addr  = 5'($urandom_range(31));
        w_data  = $urandom;
      end
      pw  = ($urandom_range(1) == 1) && !m_hold;
      pa  = 5'($urandom_range(31));
      pd  = $urandom;
      iss = ($urandom_range(3) == 0);
      ird = 5'($urandom_range(31));
      rs1 = 5'($urandom_range(31));
      rs2 = 5'($urandom_range(31));
      rd  = 5'($urandom_range(31));
      rst = r;
      drive(pw, pa, pd, waiting, waiting ? w_addr : 5'd0, waiting ? w_data : 32'd0,
            iss, ird, rs1, rs2, rd);
      settle();
      wins    = r && waiting && (!pw || m_hold);
      e_stall = r && (m_pend[rs1] || m_pend[rs2] || m_pend[rd]);
      e_addr  = wins ? w_addr : ((r && pw) ? pa : 5'd0);
      e_data  = wins ? w_data : ((r && pw) ? pd : 32'd0);
      chk_all($sformatf("rnd%0d", cyc), wins, (wins || (r && pw)) && (e_addr != 0),
              e_addr, e_data, e_stall, m_hold, m_err);
      if (!r) begin
        foreach (m_pend[i]) m_pend[i] = 0;
        m_blocked = 0; m_hold = 0; m_err = 0; waiting = 0;
      end else begin
        if (pw && m_hold) m_err = 1;
        if (iss && ird != 0 && m_pend[ird] && !(wins && w_addr == ird)) m_err = 1;
        if (wins || m_hold) m_blocked = 0;
        else if (waiting) m_blocked = (m_blocked + 1 > LIMIT) ? LIMIT : m_blocked + 1;
        if (wins) begin
          m_pend[w_addr] = 0;
          waiting = 0;
        end
        if (iss && ird != 0) m_pend[ird] = 1;
        m_hold = (m_blocked == LIMIT);
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
